// File: rtl/line_track_fsm.sv
// Line-tracking decision stage: syncs and debounces three IR inputs, decodes the motor mode,
// and (with LINE_TRACK_SEARCH_EN defined) runs lost-line search/halt recovery.
module line_track_fsm #(
   parameter int unsigned SAMPLE_DIV   = 1000,
   parameter int unsigned FILT_LEN     = 8,
   parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_signal,
   input  logic       mid_signal,
   input  logic       right_signal,
   output logic [2:0] mode,
   output logic       line_lost
);

   localparam int unsigned CW = $clog2(SAMPLE_DIV);
   localparam int unsigned FW = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
   localparam logic [FW-1:0] FLIP_AT   = FW'(FILT_LEN - 1);

   localparam logic [2:0] M_LEFT     = 3'b000;
   localparam logic [2:0] M_RIGHT    = 3'b001;
   localparam logic [2:0] M_STRAIGHT = 3'b010;
   localparam logic [2:0] M_STOP     = 3'b011;
   localparam logic [2:0] M_SHARP_L  = 3'b100;
   localparam logic [2:0] M_SHARP_R  = 3'b101;

   logic [2:0]          sync1_q, sync2_q;
   logic [CW-1:0]       div_q, div_d;
   logic                tick;
   logic [2:0]          filt_q, filt_d;
   logic [2:0][FW-1:0]  fcnt_q, fcnt_d;
   logic [2:0]          mode_q;
   logic                lost_q;
   logic [2:0]          dec_mode, track_mode;
   logic                dec_hold, dec_lost;

   assign mode      = mode_q;
   assign line_lost = lost_q;

   // Bit order throughout is {L,M,R}
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {left_signal, mid_signal, right_signal};
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      tick  = (div_q == TICK_LAST);
      div_d = tick ? '0 : div_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
   end

   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (tick) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FLIP_AT) begin
               filt_d[i] = ~filt_q[i];
               fcnt_d[i] = '0;
            end else begin
               fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= '0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end

   always_comb begin
      dec_mode = M_STRAIGHT;
      dec_hold = 1'b0;
      dec_lost = 1'b0;
      case (filt_q)
         3'b010, 3'b111: dec_mode = M_STRAIGHT;
         3'b110:         dec_mode = M_LEFT;
         3'b100:         dec_mode = M_SHARP_L;
         3'b011:         dec_mode = M_RIGHT;
         3'b001:         dec_mode = M_SHARP_R;
         3'b101:         dec_hold = 1'b1;
         default:        dec_lost = 1'b1;
      endcase
      // Ambiguous 101 keeps whatever the motor is already doing
      track_mode = dec_hold ? mode_q : dec_mode;
   end

`ifdef LINE_TRACK_SEARCH_EN
   localparam int unsigned LW = $clog2(LOST_TIMEOUT);
   localparam logic [LW-1:0] LOST_LAST = LW'(LOST_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_SEARCH, S_HALT} state_t;

   state_t        state_q;
   logic          last_left_q;
   logic [LW-1:0] lost_cnt_q;
   logic [2:0]    search_mode;

   assign search_mode = last_left_q ? M_SHARP_L : M_SHARP_R;

   // Outputs are loaded with the value belonging to the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= M_STOP;
         lost_q      <= 1'b0;
         last_left_q <= 1'b1;
         lost_cnt_q  <= '0;
      end else begin
         if (dec_mode == M_LEFT || dec_mode == M_SHARP_L)
            last_left_q <= 1'b1;
         else if (dec_mode == M_RIGHT || dec_mode == M_SHARP_R)
            last_left_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (!dec_lost) begin
                  state_q <= S_TRACK;
                  mode_q  <= track_mode;
               end
            end
            S_TRACK: begin
               if (dec_lost) begin
                  state_q    <= S_SEARCH;
                  lost_cnt_q <= '0;
                  mode_q     <= search_mode;
               end else begin
                  mode_q <= track_mode;
               end
            end
            S_SEARCH: begin
               if (!dec_lost) begin
                  state_q    <= S_TRACK;
                  lost_cnt_q <= '0;
                  mode_q     <= track_mode;
               end else if (lost_cnt_q == LOST_LAST) begin
                  state_q <= S_HALT;
                  mode_q  <= M_STOP;
                  lost_q  <= 1'b1;
               end else begin
                  if (lost_cnt_q != '1) lost_cnt_q <= lost_cnt_q + LW'(1);
                  mode_q <= search_mode;
               end
            end
            S_HALT: begin
               mode_q <= M_STOP;
               lost_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               mode_q  <= M_STOP;
               lost_q  <= 1'b0;
            end
         endcase
      end
   end
`else
   typedef enum logic {S_IDLE, S_TRACK} state_t;

   state_t state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= M_STOP;
         lost_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!dec_lost) begin
                  state_q <= S_TRACK;
                  mode_q  <= track_mode;
               end
            end
            S_TRACK: begin
               if (dec_lost) begin
                  mode_q <= M_STOP;
                  lost_q <= 1'b1;
               end else begin
                  mode_q <= track_mode;
                  lost_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               mode_q  <= M_STOP;
               lost_q  <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_line_track_fsm.sv
// Self-checking bench for line_track_fsm: vector table, directed corner sequences and
// randomized patterns compared cycle-by-cycle against a behavioural model.
module tb_line_track_fsm;

   localparam int unsigned SD = 4;
   localparam int unsigned FL = 3;
   localparam int unsigned LT = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] pat_in = 3'b000;
   logic [2:0] mode;
   logic       line_lost;

   always #5 clk = ~clk;

   line_track_fsm #(.SAMPLE_DIV(SD), .FILT_LEN(FL), .LOST_TIMEOUT(LT)) dut (
      .clk          (clk),
      .rst          (rst),
      .left_signal  (pat_in[2]),
      .mid_signal   (pat_in[1]),
      .right_signal (pat_in[0]),
      .mode         (mode),
      .line_lost    (line_lost)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Pattern {L,M,R} -> mode code; -1 = no line, -2 = keep current mode
   int dec_tab[8] = '{-1, 5, 2, 1, 4, -2, 0, 2};

   bit         m_valid = 0;
   int         m_cyc;
   bit [2:0]   m_h1, m_h2, m_filt;
   int         m_dis[3];
   bit         m_started;
   bit [2:0]   m_mode;
   bit         m_lost;
`ifdef LINE_TRACK_SEARCH_EN
   bit         m_search, m_halt, m_left;
   int         m_n;
`endif

   task automatic model_step();
      bit [2:0] p;
      int d;
      bit tk;
      if (rst) begin
         m_valid = 1; m_cyc = 0; m_h1 = 0; m_h2 = 0; m_filt = 0;
         for (int i = 0; i < 3; i++) m_dis[i] = 0;
         m_started = 0; m_mode = 3'b011; m_lost = 0;
`ifdef LINE_TRACK_SEARCH_EN
         m_search = 0; m_halt = 0; m_left = 1; m_n = 0;
`endif
         return;
      end
      p = m_filt;
      d = dec_tab[p];
      if (!m_started) begin
         if (p != 0) begin
            m_started = 1;
            if (d >= 0) m_mode = 3'(d);
         end
      end else begin
`ifdef LINE_TRACK_SEARCH_EN
         if (m_halt) begin
            m_mode = 3'b011;
         end else if (p != 0) begin
            m_search = 0;
            if (d >= 0) m_mode = 3'(d);
         end else if (!m_search) begin
            m_search = 1; m_n = 0;
            m_mode = m_left ? 3'b100 : 3'b101;
         end else if (m_n == LT - 1) begin
            m_halt = 1; m_mode = 3'b011; m_lost = 1;
         end else begin
            m_n++;
            m_mode = m_left ? 3'b100 : 3'b101;
         end
`else
         if (p == 0) begin
            m_mode = 3'b011; m_lost = 1;
         end else begin
            m_lost = 0;
            if (d >= 0) m_mode = 3'(d);
         end
`endif
      end
`ifdef LINE_TRACK_SEARCH_EN
      if (d == 0 || d == 4) m_left = 1;
      else if (d == 1 || d == 5) m_left = 0;
`endif
      tk = ((m_cyc % SD) == SD - 1);
      m_cyc++;
      if (tk) begin
         for (int i = 0; i < 3; i++) begin
            if (m_h2[i] != m_filt[i]) begin
               m_dis[i]++;
               if (m_dis[i] == FL) begin
                  m_filt[i] = ~m_filt[i];
                  m_dis[i] = 0;
               end
            end else begin
               m_dis[i] = 0;
            end
         end
      end
      m_h2 = m_h1;
      m_h1 = pat_in;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) begin
         n_cmp++;
         if (mode !== m_mode || line_lost !== m_lost) begin
            n_bad++;
            $display("FAIL model t=%0t: mode=%b line_lost=%b, expected mode=%b line_lost=%b",
                     $time, mode, line_lost, m_mode, m_lost);
         end
      end
   endtask

   task automatic check(input string name, input logic [2:0] want_mode, input logic want_lost);
      n_cmp++;
      if (mode !== want_mode || line_lost !== want_lost) begin
         n_bad++;
         $display("FAIL %s: mode=%b line_lost=%b, expected mode=%b line_lost=%b",
                  name, mode, line_lost, want_mode, want_lost);
      end
   endtask

   task automatic wait_mode(input string name, input logic [2:0] want, input int budget);
      int k = 0;
      while (mode !== want && k < budget) begin
         step();
         k++;
      end
      n_cmp++;
      if (mode !== want) begin
         n_bad++;
         $display("FAIL %s: mode=%b after %0d cycles, expected %b", name, mode, k, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [2:0] pat;
      int         hold;
      logic [2:0] exp_mode;
      logic       exp_lost;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int hold;
      vecs[0] = '{3'b010, 20, 3'b010, 1'b0};
      vecs[1] = '{3'b110, 20, 3'b000, 1'b0};
      vecs[2] = '{3'b100, 20, 3'b100, 1'b0};
      vecs[3] = '{3'b011, 20, 3'b001, 1'b0};
      vecs[4] = '{3'b001, 20, 3'b101, 1'b0};
      vecs[5] = '{3'b111, 20, 3'b010, 1'b0};
      vecs[6] = '{3'b101, 20, 3'b010, 1'b0};
      vecs[7] = '{3'b010, 20, 3'b010, 1'b0};

      // Reset and idle with no line
      pat_in = 3'b000;
      do_reset();
      check("reset", 3'b011, 1'b0);
      for (int i = 0; i < 200; i++) begin
         step();
         check("idle_hold", 3'b011, 1'b0);
      end

      // Straight latency and one-tick glitch rejection
      pat_in = 3'b010;
      wait_mode("straight_latency", 3'b010, 16);
      pat_in = 3'b110;
      for (int i = 0; i < int'(SD); i++) begin
         step();
         check("glitch_pulse", 3'b010, 1'b0);
      end
      pat_in = 3'b010;
      for (int i = 0; i < 40; i++) begin
         step();
         check("glitch_after", 3'b010, 1'b0);
      end

      // Steady-state decode table
      for (int v = 0; v < 8; v++) begin
         pat_in = vecs[v].pat;
         repeat (vecs[v].hold) step();
         check($sformatf("table[%0d]", v), vecs[v].exp_mode, vecs[v].exp_lost);
      end

      // Left turns then loss of line
      pat_in = 3'b110;
      wait_mode("left_turn", 3'b000, 20);
      pat_in = 3'b100;
      wait_mode("sharp_left", 3'b100, 20);
      pat_in = 3'b000;
      repeat (30) step();
`ifdef LINE_TRACK_SEARCH_EN
      check("search_left", 3'b100, 1'b0);
`else
      check("lost_nosearch", 3'b011, 1'b1);
`endif

      // Timeout after losing the line on the right
      do_reset();
      check("reset_mid", 3'b011, 1'b0);
      pat_in = 3'b011;
      wait_mode("right_turn", 3'b001, 20);
      pat_in = 3'b001;
      wait_mode("sharp_right", 3'b101, 20);
      pat_in = 3'b000;
      repeat (60) step();
`ifdef LINE_TRACK_SEARCH_EN
      check("search_right", 3'b101, 1'b0);
      repeat (100) step();
      check("halt", 3'b011, 1'b1);
      pat_in = 3'b010;
      repeat (40) step();
      check("halt_sticky", 3'b011, 1'b1);
      do_reset();
      check("reset_from_halt", 3'b011, 1'b0);
      wait_mode("reacquire_after_rst", 3'b010, 20);
      check("track_after_rst", 3'b010, 1'b0);
`else
      check("lost_a", 3'b011, 1'b1);
      repeat (100) step();
      check("lost_b", 3'b011, 1'b1);
      pat_in = 3'b010;
      wait_mode("recover", 3'b010, 20);
      check("recover_lost", 3'b010, 1'b0);
`endif

      // Reacquire mid-search, then ambiguous pattern
      pat_in = 3'b000;
`ifdef LINE_TRACK_SEARCH_EN
      wait_mode("enter_search", 3'b100, 20);
      repeat (50) step();
      check("search_mid", 3'b100, 1'b0);
`else
      wait_mode("enter_lost", 3'b011, 20);
      check("lost_flag", 3'b011, 1'b1);
`endif
      pat_in = 3'b010;
      wait_mode("reacquire", 3'b010, 20);
      check("reacquire_state", 3'b010, 1'b0);
      pat_in = 3'b101;
      repeat (30) step();
      check("ambiguous_hold", 3'b010, 1'b0);

      // Randomized patterns against the model
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         pat_in = 3'($urandom_range(0, 7));
         if (pat_in == 3'b000 && $urandom_range(0, 2) == 0) hold = 130;
         else hold = int'($urandom_range(1, 24));
         repeat (hold) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, expected completion before 5 ms");
      $fatal(1);
   end

endmodule
